// File: rtl/lc3b_mem_arbiter_pkg.sv
// Shared types and constants for the LC-3b memory arbiter.
package lc3b_mem_arbiter_pkg;

    // Arbiter FSM state encoding
    typedef logic [1:0] lc3b_arb_state_t;

    localparam lc3b_arb_state_t ARB_IDLE = 2'd0;
    localparam lc3b_arb_state_t ARB_BUSY = 2'd1;
    localparam lc3b_arb_state_t ARB_DONE = 2'd2;

    // Width of a channel index; never narrower than one bit.
    function automatic int idx_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/lc3b_mem_arbiter_rr_pick.sv
// Combinational winner selection: round-robin from last_grant+1, or fixed
// priority (lowest index) when RR is 0.
module lc3b_mem_arbiter_rr_pick
    import lc3b_mem_arbiter_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int RR     = 1
) (
    input  logic [NUM_CH-1:0]               request,
    input  logic [idx_width(NUM_CH)-1:0]    last_grant,
    output logic                            grant_valid,
    output logic [idx_width(NUM_CH)-1:0]    grant_idx
);

    localparam int IDX_W = idx_width(NUM_CH);

    logic [NUM_CH-1:0] upper_mask;
    logic [NUM_CH-1:0] upper_req;
    logic [NUM_CH-1:0] pick_vec;

    // Channels strictly above the last grant get first look in round-robin
    // mode; in fixed-priority mode the mask is empty so the scan starts at 0.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_mask
            assign upper_mask[gi] = (RR != 0) && (IDX_W'(gi) > last_grant);
        end
    endgenerate

    assign upper_req   = request & upper_mask;
    assign pick_vec    = (|upper_req) ? upper_req : request;
    assign grant_valid = |request;

    // Lowest set bit of the candidate vector (wrap-around handled by pick_vec)
    always_comb begin
        grant_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pick_vec[i]) begin
                grant_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/lc3b_mem_arbiter.sv
// N-channel memory arbiter for the LC-3b pipeline: one granted transaction at
// a time, latched request, registered memory strobes and one-cycle response.
module lc3b_mem_arbiter
    import lc3b_mem_arbiter_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RR     = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          ch_request,
    input  logic [NUM_CH-1:0]          ch_write_enable,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_address,
    input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
    output logic [NUM_CH-1:0]          ch_response,
    output logic [DATA_W-1:0]          ch_rdata,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [ADDR_W-1:0]          mem_address,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata,
    input  logic                       mem_resp
);

    localparam int IDX_W = idx_width(NUM_CH);
    typedef logic [IDX_W-1:0] grant_idx_t;

    lc3b_arb_state_t   state_reg;
    grant_idx_t        grant_reg;
    grant_idx_t        last_grant_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;

    logic              mem_read_reg;
    logic              mem_write_reg;
    logic [ADDR_W-1:0] mem_address_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic [DATA_W-1:0] ch_rdata_reg;
    logic [NUM_CH-1:0] ch_response_reg;
    logic [NUM_CH-1:0] ch_response_next;

    logic              pick_valid;
    grant_idx_t        pick_idx;
    logic              strobe_active;
    logic              mem_done;

    logic [ADDR_W-1:0] addr_by_ch  [NUM_CH];
    logic [DATA_W-1:0] wdata_by_ch [NUM_CH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_slice
            assign addr_by_ch[gi]  = ch_address[gi*ADDR_W +: ADDR_W];
            assign wdata_by_ch[gi] = ch_wdata[gi*DATA_W +: DATA_W];
            assign ch_response_next[gi] = (state_reg == ARB_DONE) &&
                                          (grant_reg == grant_idx_t'(gi));
        end
    endgenerate

    lc3b_mem_arbiter_rr_pick #(
        .NUM_CH (NUM_CH),
        .RR     (RR)
    ) u_pick (
        .request     (ch_request),
        .last_grant  (last_grant_reg),
        .grant_valid (pick_valid),
        .grant_idx   (pick_idx)
    );

    // A memory response only counts once the strobe is actually on the bus.
    assign strobe_active = mem_read_reg | mem_write_reg;
    assign mem_done      = (state_reg == ARB_BUSY) && strobe_active && mem_resp;

    // FSM plus request latch: requests are only looked at in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ARB_IDLE;
            grant_reg      <= '0;
            last_grant_reg <= grant_idx_t'(NUM_CH - 1);
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
        end else begin
            case (state_reg)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        grant_reg      <= pick_idx;
                        last_grant_reg <= pick_idx;
                        we_reg         <= ch_write_enable[pick_idx];
                        addr_reg       <= addr_by_ch[pick_idx];
                        wdata_reg      <= wdata_by_ch[pick_idx];
                        state_reg      <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (mem_done) begin
                        state_reg <= ARB_DONE;
                    end
                end
                ARB_DONE: state_reg <= ARB_IDLE;
                default:  state_reg <= ARB_IDLE;
            endcase
        end
    end

    // Memory-side registers: raised one cycle into BUSY, held until mem_resp
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_read_reg    <= 1'b0;
            mem_write_reg   <= 1'b0;
            mem_address_reg <= '0;
            mem_wdata_reg   <= '0;
        end else if (mem_done) begin
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
        end else if ((state_reg == ARB_BUSY) && !strobe_active) begin
            mem_read_reg    <= ~we_reg;
            mem_write_reg   <= we_reg;
            mem_address_reg <= addr_reg;
            mem_wdata_reg   <= wdata_reg;
        end
    end

    // Read data is captured only on completed reads and held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_rdata_reg <= '0;
        end else if (mem_done && mem_read_reg) begin
            ch_rdata_reg <= mem_rdata;
        end
    end

    // One-hot completion pulse, one cycle, for the granted channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_response_reg <= '0;
        end else begin
            ch_response_reg <= ch_response_next;
        end
    end

    assign ch_response = ch_response_reg;
    assign ch_rdata    = ch_rdata_reg;
    assign mem_read    = mem_read_reg;
    assign mem_write   = mem_write_reg;
    assign mem_address = mem_address_reg;
    assign mem_wdata   = mem_wdata_reg;

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Self-checking bench: dut 0 is a 4-channel round-robin arbiter, dut 1 a
// 4-channel fixed-priority arbiter. A transaction-level model predicts
// winners, strobe windows, response pulses and read data.
module tb_lc3b_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req       [2];
    logic [N-1:0]    wen       [2];
    logic [N*AW-1:0] addr_bus  [2];
    logic [N*DW-1:0] wdata_bus [2];
    logic [N-1:0]    resp      [2];
    logic [DW-1:0]   rdata     [2];
    logic            mrd       [2];
    logic            mwr       [2];
    logic [AW-1:0]   maddr     [2];
    logic [DW-1:0]   mwdata    [2];
    logic [DW-1:0]   mrdata    [2];
    logic            mresp     [2];

    lc3b_mem_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .RR(1)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .ch_request(req[0]), .ch_write_enable(wen[0]),
        .ch_address(addr_bus[0]), .ch_wdata(wdata_bus[0]),
        .ch_response(resp[0]), .ch_rdata(rdata[0]),
        .mem_read(mrd[0]), .mem_write(mwr[0]),
        .mem_address(maddr[0]), .mem_wdata(mwdata[0]),
        .mem_rdata(mrdata[0]), .mem_resp(mresp[0])
    );

    lc3b_mem_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .RR(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .ch_request(req[1]), .ch_write_enable(wen[1]),
        .ch_address(addr_bus[1]), .ch_wdata(wdata_bus[1]),
        .ch_response(resp[1]), .ch_rdata(rdata[1]),
        .mem_read(mrd[1]), .mem_write(mwr[1]),
        .mem_address(maddr[1]), .mem_wdata(mwdata[1]),
        .mem_rdata(mrdata[1]), .mem_resp(mresp[1])
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Transaction-level model state
    int            m_last  [2];
    logic [DW-1:0] m_rdata [2];
    bit            busy, gwait, strobe_on, resp_pend;
    int            free_edge, win, mem_cnt;
    bit            l_we;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata;
    logic [N-1:0]  exp_resp;
    int            gap [N];

    // Bench control
    bit            auto_mode, hold_mode;
    int            lat_cfg;
    logic [DW-1:0] rdata_cfg;
    int            grant_log [$];
    bit            saw_resp;
    logic [N-1:0]  last_resp_vec;
    logic [DW-1:0] last_rdata_seen;

    typedef struct {
        int            ch;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] mdata;
        int            lat;
        logic [N-1:0]  exp_resp;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int last, input bit rr);
        if (rr) begin
            for (int i = 1; i <= N; i++) begin
                if (r[(last + i) % N]) return (last + i) % N;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (r[i]) return i;
            end
        end
        return -1;
    endfunction

    task automatic model_reset();
        busy = 0; gwait = 0; strobe_on = 0; resp_pend = 0;
        free_edge = 0; win = 0; mem_cnt = 0;
        l_we = 0; l_addr = '0; l_wdata = '0;
        m_last[0] = N - 1; m_last[1] = N - 1;
        m_rdata[0] = '0; m_rdata[1] = '0;
        for (int c = 0; c < N; c++) gap[c] = 0;
    endtask

    task automatic new_values(input int d, input int c);
        addr_bus[d][c*AW +: AW]  = AW'($urandom);
        wdata_bus[d][c*DW +: DW] = DW'($urandom);
        wen[d][c]                = 1'($urandom_range(0, 1));
    endtask

    task automatic set_channel(input int d, input int c, input bit we,
                               input logic [AW-1:0] a, input logic [DW-1:0] w);
        addr_bus[d][c*AW +: AW]  = a;
        wdata_bus[d][c*DW +: DW] = w;
        wen[d][c]                = we;
        req[d][c]                = 1'b1;
    endtask

    // One clock of dut d: advance the model, compare, then drive next inputs
    task automatic step(input int d);
        @(posedge clk);
        #1;
        cyc++;
        exp_resp = '0;
        if (resp_pend) begin
            exp_resp[win] = 1'b1;
            resp_pend = 0;
            busy = 0;
            free_edge = cyc + 1;
        end
        if (strobe_on && mresp[d]) begin
            strobe_on = 0;
            resp_pend = 1;
            if (!l_we) m_rdata[d] = mrdata[d];
        end
        if (gwait) begin
            gwait = 0;
            strobe_on = 1;
            mem_cnt = auto_mode ? int'($urandom_range(1, 4)) : lat_cfg;
        end
        if (!busy && cyc >= free_edge && req[d] != '0) begin
            win = pick(req[d], m_last[d], d == 0);
            m_last[d] = win;
            busy = 1;
            gwait = 1;
            l_we    = wen[d][win];
            l_addr  = addr_bus[d][win*AW +: AW];
            l_wdata = wdata_bus[d][win*DW +: DW];
        end

        check("mem_read", 64'(mrd[d]), 64'(strobe_on && !l_we));
        check("mem_write", 64'(mwr[d]), 64'(strobe_on && l_we));
        if (strobe_on) begin
            check("mem_address", 64'(maddr[d]), 64'(l_addr));
            check("mem_wdata", 64'(mwdata[d]), 64'(l_wdata));
        end
        check("ch_response", 64'(resp[d]), 64'(exp_resp));
        check("ch_rdata", 64'(rdata[d]), 64'(m_rdata[d]));
        if (exp_resp != '0) begin
            $display("[%0d] dut%0d ch%0d %s addr=%h wdata=%h ch_rdata=%h resp=%b",
                     cyc, d, win, l_we ? "WR" : "RD", l_addr, l_wdata, rdata[d], resp[d]);
            grant_log.push_back(win);
            saw_resp = 1;
            last_resp_vec = resp[d];
            last_rdata_seen = rdata[d];
        end

        // Memory model: respond on the last cycle of the programmed latency;
        // stray mem_resp pulses while idle must be ignored by the arbiter.
        mresp[d] = 1'b0;
        if (strobe_on) begin
            if (mem_cnt == 1) begin
                mresp[d]  = 1'b1;
                mrdata[d] = auto_mode ? DW'($urandom) : rdata_cfg;
            end else begin
                mrdata[d] = DW'($urandom);
            end
            mem_cnt--;
        end else if (auto_mode && !busy) begin
            mresp[d] = ($urandom_range(0, 7) == 0);
        end

        // Requesters
        for (int c = 0; c < N; c++) begin
            if (exp_resp[c]) begin
                new_values(d, c);
                if (auto_mode) begin
                    gap[c] = $urandom_range(0, 3);
                    req[d][c] = (gap[c] == 0);
                end else begin
                    req[d][c] = hold_mode;
                end
            end else if (auto_mode) begin
                if (!req[d][c]) begin
                    if (gap[c] > 0) gap[c]--;
                    else begin
                        new_values(d, c);
                        req[d][c] = 1'b1;
                    end
                end else if (busy && c == win && $urandom_range(0, 15) == 0) begin
                    req[d][c] = 1'b0;
                    gap[c] = $urandom_range(0, 3);
                end
            end
        end
    endtask

    task automatic drain(input int d);
        auto_mode = 0;
        hold_mode = 0;
        for (int t = 0; t < 200; t++) begin
            if (req[d] == '0 && !busy) break;
            step(d);
        end
        check("drain_idle", 64'(busy || req[d] != '0), 64'(0));
    endtask

    vec_t vecs [5];

    initial begin
        for (int d = 0; d < 2; d++) begin
            req[d] = '0; wen[d] = '0; addr_bus[d] = '0; wdata_bus[d] = '0;
            mrdata[d] = '0; mresp[d] = 1'b0;
        end
        auto_mode = 0; hold_mode = 0; lat_cfg = 1; rdata_cfg = '0;
        saw_resp = 0; last_resp_vec = '0; last_rdata_seen = '0;
        model_reset();

        vecs[0] = '{ch: 1, we: 0, addr: 16'h3000, wdata: 16'h0000, mdata: 16'hBEEF, lat: 4, exp_resp: 4'b0010, exp_rdata: 16'hBEEF};
        vecs[1] = '{ch: 0, we: 1, addr: 16'h0040, wdata: 16'h1234, mdata: 16'hDEAD, lat: 2, exp_resp: 4'b0001, exp_rdata: 16'hBEEF};
        vecs[2] = '{ch: 3, we: 0, addr: 16'h00FF, wdata: 16'h7777, mdata: 16'h0001, lat: 1, exp_resp: 4'b1000, exp_rdata: 16'h0001};
        vecs[3] = '{ch: 2, we: 1, addr: 16'hFFFF, wdata: 16'hA5A5, mdata: 16'h5555, lat: 3, exp_resp: 4'b0100, exp_rdata: 16'h0001};
        vecs[4] = '{ch: 0, we: 0, addr: 16'h0000, wdata: 16'h0000, mdata: 16'hFFFF, lat: 2, exp_resp: 4'b0001, exp_rdata: 16'hFFFF};

        // Reset: outputs cleared while held, FSM idle for 10 cycles after
        #12;
        for (int d = 0; d < 2; d++) begin
            check("rst_mem_read", 64'(mrd[d]), 64'(0));
            check("rst_mem_write", 64'(mwr[d]), 64'(0));
            check("rst_mem_address", 64'(maddr[d]), 64'(0));
            check("rst_mem_wdata", 64'(mwdata[d]), 64'(0));
            check("rst_ch_rdata", 64'(rdata[d]), 64'(0));
            check("rst_ch_response", 64'(resp[d]), 64'(0));
        end
        #11 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step(0);

        // Round-robin fairness: all four hold requests, 1-cycle memory
        hold_mode = 1; lat_cfg = 1; rdata_cfg = 16'h0F0F;
        for (int c = 0; c < N; c++) set_channel(0, c, 1'b0, AW'(16'h0100 + c), DW'(0));
        grant_log.delete();
        for (int t = 0; t < 100 && grant_log.size() < 5; t++) step(0);
        check("rr_count", 64'(grant_log.size()), 64'(5));
        for (int i = 0; i < 5 && i < grant_log.size(); i++) check("rr_order", 64'(grant_log[i]), 64'(i % N));
        drain(0);

        // Fixed priority: channels 0 and 2 requesting, 0 always wins
        hold_mode = 1; lat_cfg = 1; rdata_cfg = 16'h2222;
        set_channel(1, 0, 1'b0, 16'h0200, 16'h0000);
        set_channel(1, 2, 1'b1, 16'h0202, 16'hCAFE);
        grant_log.delete();
        for (int t = 0; t < 100 && grant_log.size() < 4; t++) step(1);
        check("fp_count", 64'(grant_log.size()), 64'(4));
        foreach (grant_log[i]) check("fp_winner", 64'(grant_log[i]), 64'(0));
        req[1][0] = 1'b0;
        grant_log.delete();
        drain(1);
        check("fp_ch2_count", 64'(grant_log.size()), 64'(1));
        if (grant_log.size() > 0) check("fp_ch2_winner", 64'(grant_log[0]), 64'(2));

        // Table of single transactions on the round-robin arbiter
        for (int v = 0; v < 5; v++) begin
            lat_cfg = vecs[v].lat;
            rdata_cfg = vecs[v].mdata;
            hold_mode = 0;
            set_channel(0, vecs[v].ch, vecs[v].we, vecs[v].addr, vecs[v].wdata);
            saw_resp = 0;
            for (int t = 0; t < 40 && !saw_resp; t++) step(0);
            check("tbl_seen", 64'(saw_resp), 64'(1));
            check("tbl_resp", 64'(last_resp_vec), 64'(vecs[v].exp_resp));
            check("tbl_rdata", 64'(last_rdata_seen), 64'(vecs[v].exp_rdata));
            for (int t = 0; t < 3; t++) step(0);
        end

        // Randomized traffic against the model on both arbiters
        auto_mode = 1;
        for (int t = 0; t < 400; t++) step(0);
        drain(0);
        auto_mode = 1;
        for (int t = 0; t < 300; t++) step(1);
        drain(1);

        // Reset in the middle of a long read
        lat_cfg = 20; rdata_cfg = 16'h9999;
        set_channel(0, 0, 1'b0, 16'h0100, 16'h0000);
        for (int t = 0; t < 10 && !mrd[0]; t++) step(0);
        check("mid_strobe_up", 64'(mrd[0]), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_read", 64'(mrd[0]), 64'(0));
        check("mid_rst_write", 64'(mwr[0]), 64'(0));
        check("mid_rst_resp", 64'(resp[0]), 64'(0));
        check("mid_rst_rdata", 64'(rdata[0]), 64'(0));
        req[0] = '0;
        mresp[0] = 1'b1;
        mrdata[0] = 16'h9999;
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(posedge clk);
            #1;
            mresp[0] = 1'b0;
            check("late_resp_ignored", 64'(resp[0]), 64'(0));
            check("late_no_strobe", 64'(mrd[0] | mwr[0]), 64'(0));
        end
        model_reset();
        set_channel(0, 3, 1'b0, 16'h0303, 16'h0000);
        set_channel(0, 1, 1'b0, 16'h0101, 16'h0000);
        set_channel(0, 0, 1'b1, 16'h0000, 16'h4321);
        lat_cfg = 2;
        grant_log.delete();
        drain(0);
        check("post_rst_count", 64'(grant_log.size()), 64'(3));
        if (grant_log.size() == 3) begin
            check("post_rst_first", 64'(grant_log[0]), 64'(0));
            check("post_rst_second", 64'(grant_log[1]), 64'(1));
            check("post_rst_third", 64'(grant_log[2]), 64'(3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
